// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone host initiator: default bus widths,
// FSM state encoding and the timeout counter width helper.
package wb_pkg;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = WB_DW / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } wb_state_e;

  // A disabled timeout (0) still gets a 1-bit counter so the vector stays legal.
  function automatic int ctr_width(input int cycles);
    return (cycles > 0) ? $clog2(cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Strobe-cycle counter for the initiator: cleared on request accept, counts
// while enabled, flags the last permitted cycle. TIMEOUT_CYCLES=0 never expires.
module wb_timeout_ctr
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int CW = ctr_width(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_q;

  // Holding at the expiry value keeps the counter from ever wrapping.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expire_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
      assign expire_o = 1'b0;
    end else begin : g_timeout
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
      assign expire_o = en_i && (cnt_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/wb_host_initiator.sv
// Wishbone classic single-transfer initiator: one valid/ready request becomes one
// WB cycle and a one-cycle response pulse. Define WB_INIT_ERR_EN to add wbm_err_i.
module wb_host_initiator
  import wb_pkg::*;
#(
  parameter int AW             = WB_AW,
  parameter int DW             = WB_DW,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [AW-1:0]   req_adr,
  input  logic [DW-1:0]   req_dat,
  input  logic [DW/8-1:0] req_sel,
  output logic            rsp_valid,
  output logic [DW-1:0]   rsp_dat,
  output logic            rsp_err,
  output logic            wbm_cyc_o,
  output logic            wbm_stb_o,
  output logic            wbm_we_o,
  output logic [DW/8-1:0] wbm_sel_o,
  output logic [AW-1:0]   wbm_adr_o,
  output logic [DW-1:0]   wbm_dat_o,
  input  logic            wbm_ack_i,
  input  logic [DW-1:0]   wbm_dat_i
`ifdef WB_INIT_ERR_EN
  ,
  input  logic            wbm_err_i
`endif
);

  wb_state_e       state_q;
  logic            cyc_q;
  logic            we_q;
  logic [AW-1:0]   adr_q;
  logic [DW-1:0]   dat_q;
  logic [DW/8-1:0] sel_q;
  logic            req_ready_q;
  logic            rsp_valid_q;
  logic [DW-1:0]   rsp_dat_q;
  logic            rsp_err_q;

  logic accept;
  logic bus_err;
  logic expire;

  assign accept = req_valid && req_ready_q;

`ifdef WB_INIT_ERR_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  wb_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i   (wb_clk_i),
    .rst_ni  (wb_rst_ni),
    .clr_i   (accept),
    .en_i    (state_q == ST_BUS),
    .expire_o(expire)
  );

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      // NOTE: the captured request fields are reset as well so every bus output is 0 out of reset.
      state_q     <= ST_IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register updates from the same pre-edge values.
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            state_q     <= ST_BUS;
            req_ready_q <= 1'b0;
            cyc_q       <= 1'b1;
            we_q        <= req_we;
            adr_q       <= req_adr;
            dat_q       <= req_dat;
            sel_q       <= req_sel;
          end
        end
        ST_BUS: begin
          // Priority: bus error, then ack, then timeout (ack on the last cycle still succeeds).
          if (bus_err || wbm_ack_i || expire) begin
            state_q     <= ST_RESP;
            cyc_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            if (bus_err || !wbm_ack_i) begin
              rsp_err_q <= 1'b1;
              rsp_dat_q <= '0;
            end else begin
              rsp_err_q <= 1'b0;
              rsp_dat_q <= we_q ? '0 : wbm_dat_i;
            end
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_dat_q   <= '0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= ST_IDLE;
          cyc_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
          rsp_err_q   <= 1'b0;
          rsp_dat_q   <= '0;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_dat   = rsp_dat_q;
  assign rsp_err   = rsp_err_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign wbm_we_o  = we_q;
  assign wbm_sel_o = sel_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;

endmodule

// File: tb/tb_wb_host_initiator.sv
// Scoreboard bench for wb_host_initiator: random requests against a slave model,
// expected responses derived from the transfer rules and checked by a monitor.
module tb_wb_host_initiator;

  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  typedef struct {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    int          dly;      // stb cycle (1-based) on which the slave responds
    logic [31:0] rd;       // read data the slave returns
    logic        err;      // slave answers with err instead of a clean ack
    int          stb_exp;  // expected strobe length, 0 = transfer will be reset away
  } txn_t;

  typedef struct {
    logic [31:0] dat;
    logic        err;
    longint      cyc;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_adr = '0;
  logic [31:0] req_dat = '0;
  logic [3:0]  req_sel = '0;
  logic        rsp_valid;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o;
  logic        wbm_ack_i = 1'b0;
  logic [31:0] wbm_dat_i = '0;
`ifdef WB_INIT_ERR_EN
  logic        wbm_err_i = 1'b0;
`endif

  int     total = 0;
  int     bad = 0;
  longint cyc_n = 0;
  txn_t   slv_q[$];
  rsp_t   exp_q[$];

  wb_host_initiator #(
    .AW(32), .DW(32), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_ni(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_adr  (req_adr),
    .req_dat  (req_dat),
    .req_sel  (req_sel),
    .rsp_valid(rsp_valid),
    .rsp_dat  (rsp_dat),
    .rsp_err  (rsp_err),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_ack_i(wbm_ack_i),
    .wbm_dat_i(wbm_dat_i)
`ifdef WB_INIT_ERR_EN
    ,
    .wbm_err_i(wbm_err_i)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  // Reference rules: response arrives on stb cycle dly unless the timeout window closes first.
  function automatic int stb_len(input txn_t t);
    return (t.dly <= TMO) ? t.dly : TMO;
  endfunction

  function automatic rsp_t model(input txn_t t, input longint p);
    rsp_t r;
    r.err = (t.dly > TMO) || t.err;
    r.dat = (r.err || t.we) ? 32'h0 : t.rd;
    r.cyc = p + longint'(stb_len(t)) + 1;
    return r;
  endfunction

  // Slave: checks bus fields while cyc is high, answers on the programmed cycle,
  // and drives stray ack/err whenever no cycle is in progress.
  txn_t cur;
  bit   active = 1'b0;
  int   n_stb = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      active    = 1'b0;
      wbm_ack_i = 1'b0;
`ifdef WB_INIT_ERR_EN
      wbm_err_i = 1'b0;
`endif
    end else if (wbm_cyc_o) begin
      if (!active) begin
        if (slv_q.size() == 0) begin
          check("slave_unexpected_cyc", {63'h0, wbm_cyc_o}, 64'h0);
        end else begin
          cur    = slv_q.pop_front();
          active = 1'b1;
          n_stb  = 0;
        end
      end
      if (active) begin
        n_stb++;
        check("stb_eq_cyc", {63'h0, wbm_stb_o}, 64'h1);
        check("wbm_we", {63'h0, wbm_we_o}, {63'h0, cur.we});
        check("wbm_adr", {32'h0, wbm_adr_o}, {32'h0, cur.adr});
        check("wbm_dat", {32'h0, wbm_dat_o}, {32'h0, cur.dat});
        check("wbm_sel", {60'h0, wbm_sel_o}, {60'h0, cur.sel});
`ifdef WB_INIT_ERR_EN
        wbm_err_i = (n_stb == cur.dly) && cur.err;
        wbm_ack_i = (n_stb == cur.dly) && (!cur.err || ($urandom_range(0, 1) == 1));
`else
        wbm_ack_i = (n_stb == cur.dly);
`endif
        wbm_dat_i = (n_stb == cur.dly && !cur.we) ? cur.rd : $urandom;
      end
    end else begin
      if (active) begin
        if (cur.stb_exp != 0) check("stb_length", 64'(n_stb), 64'(cur.stb_exp));
        active = 1'b0;
      end
      wbm_ack_i = ($urandom_range(0, 2) == 0);
`ifdef WB_INIT_ERR_EN
      wbm_err_i = ($urandom_range(0, 3) == 0);
`endif
      wbm_dat_i = $urandom;
    end
  end

  // Monitor: every response pulse must match the head of the expected queue.
  always @(negedge clk) begin
    rsp_t e;
    if (rst_n && rsp_valid) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", {63'h0, rsp_valid}, 64'h0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_dat", {32'h0, rsp_dat}, {32'h0, e.dat});
        check("rsp_err", {63'h0, rsp_err}, {63'h0, e.err});
        check("rsp_cycle", 64'(cyc_n), 64'(e.cyc));
        check("rsp_ready_low", {63'h0, req_ready}, 64'h0);
        check("rsp_cyc_low", {63'h0, wbm_cyc_o}, 64'h0);
      end
    end
  end

  task automatic wait_ready(input string name, output bit ok);
    int w = 0;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    ok = req_ready;
    if (!ok) check(name, {63'h0, req_ready}, 64'h1);
  endtask

  task automatic issue(input txn_t t_in, input bit hold);
    txn_t   t = t_in;
    longint p;
    int     w;
    bit     ok;
    wait_ready("ready_before_issue", ok);
    if (!ok) return;
    req_valid = 1'b1;
    req_we    = t.we;
    req_adr   = t.adr;
    req_dat   = t.dat;
    req_sel   = t.sel;
    p         = cyc_n;
    t.stb_exp = stb_len(t);
    slv_q.push_back(t);
    exp_q.push_back(model(t, p));
    @(negedge clk);
    // Inputs change (and may stay valid) while busy; the DUT must ignore them.
    req_valid = hold;
    req_we    = 1'($urandom);
    req_adr   = $urandom;
    req_dat   = $urandom;
    req_sel   = 4'($urandom);
    w = 0;
    while (!req_ready && w < 40) begin
      @(negedge clk);
      w++;
    end
    req_valid = 1'b0;
    check("ready_return_cycle", 64'(cyc_n), 64'(p + longint'(t.stb_exp) + 2));
  endtask

  function automatic txn_t mk(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                              input logic [3:0] sel, input int dly, input logic [31:0] rd,
                              input logic err);
    txn_t t;
    t.we = we; t.adr = adr; t.dat = dat; t.sel = sel;
    t.dly = dly; t.rd = rd; t.err = err; t.stb_exp = 0;
    return t;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1);
  end

  initial begin
    txn_t t;
    bit   ok;
    int   dly;
    logic e;

    #23;
    check("rst_req_ready", {63'h0, req_ready}, 64'h1);
    check("rst_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("rst_rsp_err", {63'h0, rsp_err}, 64'h0);
    check("rst_rsp_dat", {32'h0, rsp_dat}, 64'h0);
    check("rst_cyc", {62'h0, wbm_cyc_o, wbm_stb_o}, 64'h0);
    check("rst_bus_fields", {wbm_adr_o, wbm_dat_o} | {59'h0, wbm_sel_o, wbm_we_o}, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    issue(mk(1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 4, 32'h0, 1'b0), 1'b0);
    issue(mk(1'b0, 32'h3000_0008, 32'h0, 4'hF, 1, 32'h1234_5678, 1'b0), 1'b0);
    issue(mk(1'b0, 32'h3000_000C, 32'h0, 4'h3, NEVER, 32'hAAAA_5555, 1'b0), 1'b0);
    issue(mk(1'b0, 32'h3000_0010, 32'h0, 4'hF, TMO, 32'hCAFE_F00D, 1'b0), 1'b0);
    issue(mk(1'b1, 32'h3000_0014, 32'h0BAD_0BAD, 4'hC, TMO + 1, 32'h0, 1'b0), 1'b1);
`ifdef WB_INIT_ERR_EN
    issue(mk(1'b0, 32'h3000_0018, 32'h0, 4'hF, 1, 32'h7777_7777, 1'b1), 1'b0);
`endif

    for (int i = 0; i < 150; i++) begin
      dly = ($urandom_range(0, 4) == 0) ? NEVER : int'($urandom_range(1, TMO + 2));
      e   = 1'b0;
`ifdef WB_INIT_ERR_EN
      e   = (dly <= TMO) && ($urandom_range(0, 3) == 0);
`endif
      t = mk(1'($urandom), $urandom, $urandom, 4'($urandom), dly, $urandom, e);
      issue(t, 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during the second strobe cycle: bus drops at once and no response appears.
    wait_ready("ready_before_reset_test", ok);
    t = mk(1'b0, 32'h3000_0020, 32'h0, 4'hF, NEVER, 32'h0, 1'b0);
    t.stb_exp = 0;
    slv_q.push_back(t);
    req_valid = 1'b1; req_we = t.we; req_adr = t.adr; req_dat = t.dat; req_sel = t.sel;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_reset_cyc", {63'h0, wbm_cyc_o}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    check("reset_cyc_drop", {62'h0, wbm_cyc_o, wbm_stb_o}, 64'h0);
    check("reset_rsp_valid", {63'h0, rsp_valid}, 64'h0);
    check("reset_ready", {63'h0, req_ready}, 64'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_ready", {63'h0, req_ready}, 64'h1);
    repeat (6) @(negedge clk);
    issue(mk(1'b0, 32'h3000_0024, 32'h0, 4'hF, 2, 32'h5A5A_A5A5, 1'b0), 1'b0);

    repeat (4) @(negedge clk);
    check("exp_queue_drained", 64'(exp_q.size()), 64'h0);
    check("slave_queue_drained", 64'(slv_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
